halftone_stream_converter: RTL and testbench
============================================

# halftone_stream_converter

Streaming, parametrised successor to the combinational baseline halftone pixel converter. Accepts grey-scale pixels in raster order through a valid/ready handshake and quantises each pixel to one halftone bit using Floyd–Steinberg error diffusion held in a single-row error buffer. Packs each completed image row into one `htpv_row` word. Sits between the pixel source (frame buffer / DMA reader) and the halftone print-head row formatter.

## Interface
- `PIXEL_WIDTH`, 8: unsigned pixel width W.
- `ROW_LENGTH`, 8: pixels per row L (≥2).
- `NUM_ROWS`, 6: rows per frame R (≥1).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `pixel_in` in W: unsigned pixel value.
- `pixel_valid` in 1: `pixel_in` and `pixel_sof` are valid.
- `pixel_sof` in 1: this pixel is row 1, column 1 of a new frame.
- `pixel_ready` out 1: pixel accepted when `pixel_valid && pixel_ready`.
- `htpv_row` out [1:L]: halftone row; bit 1 is column 1.
- `htpv_valid` out 1: `htpv_row` valid.
- `htpv_ready` in 1: row taken when `htpv_valid && htpv_ready`.
- `htpv_row_index` out max(1,$clog2(R)): 0-based row number of `htpv_row`.
- `htpv_frame_end` out 1: `htpv_row` is row R of the frame.

## Operation
- Counters `col` (0..L-1) and `row` (0..R-1), the shift register, carry, and both error arrays `err_cur[0..L-1]` and `err_nxt[0..L-1]` are signed with W+3 bits.
- On accepted pixel p at (`row`, `col`):
  - v = p + carry + err_cur[col].
  - Output bit b = (v ≥ 2^(W-1)).
  - e = v − (b ? 2^W−1 : 0), clamped to ±(2^W−1).
- Distribution uses arithmetic shifts, so results round toward −∞:
  - carry ← (7e)>>>4. carry is forced to 0 after column L-1.
  - err_nxt[col-1] += (3e)>>>4, only if col>0.
  - err_nxt[col] += (5e)>>>4.
  - err_nxt[col+1] += (1e)>>>4, only if col<L-1.
- b is written into `htpv_row` bit col+1.
- After column L-1:
  - err_cur ← err_nxt, err_nxt ← 0, carry ← 0.
  - Row is loaded into the output register; `row` advances.
- After row R-1: `row` wraps to 0 and all errors clear.
- `pixel_sof`=1 on an accepted pixel:
  - Forces col=row=0 and zero errors and carry before the pixel is processed. This is a resync and may occur mid-frame.
  - A partially built row is discarded. A row already in the output register is unaffected.
- State machine:
  - IDLE: after reset, until the first accepted pixel.
  - FILL: accumulating a row.
  - HOLD: row pending, `htpv_valid`=1. Pixels for the next row are still accepted until its column L-1.
- `pixel_ready` = 0 only when col=L-1 and `htpv_valid` && !`htpv_ready`. This is a combinational path from `htpv_ready`.

## Timing
- Reset values:
  - `pixel_ready`=1, `htpv_valid`=0, `htpv_row`=0, `htpv_row_index`=0, `htpv_frame_end`=0.
  - Counters, errors and carry = 0.
- Throughput is one pixel per cycle with no stalls when `htpv_ready`=1.
- Latency: `htpv_valid` rises the cycle after column L-1 is accepted.
- `htpv_*` outputs stay stable while `htpv_valid` && !`htpv_ready`.
- Simultaneous output handshake and last-column accept: the new row replaces the old one in the same edge, and `htpv_valid` stays 1.
- Reset asserted mid-row: all outputs return to reset values immediately. The partial row is lost.

## Configuration
- `HALFTONE_DIFFUSION_EN` defined: error diffusion as above.
- `HALFTONE_DIFFUSION_EN` undefined:
  - Plain threshold, b = (p ≥ 2^(W-1)).
  - Carry and error arrays are not built.
  - Handshake and timing are unchanged.

## Test plan
- Stripe frame, defaults: rows 1–3 = 255×4 then 0×4, rows 4–6 inverted → rows 0xF0, 0xF0, 0xF0, 0x0F, 0x0F, 0x0F. `htpv_frame_end` is set only with index 5. The result is the same with the macro on or off, since e=0 everywhere.
- Constant 128, diffusion on → row 1 = 0xAA. Intermediate values to check: v = 128, 72, 159, 86, 165, 88, 166, 89. With the macro off → row 1 = 0xFF.
- Constant 64, diffusion on → row 1 = 0x00, and carry after column 1 = 28.
- Backpressure: hold `htpv_ready`=0 over two rows → `pixel_ready`=0 exactly at column 8 of row 2. First row is held unchanged. Release → one-cycle handover, no pixel lost.
- `pixel_sof` at row 3, column 5 → next output is row index 0. Its value equals that of a fresh frame.
- Reset pulse mid-row 2 → all outputs at reset values. First full row after reset matches the fresh-frame reference.

Source files
------------

// File: rtl/halftone_stream_converter.sv
// halftone_stream_converter
//
// Streaming grey-scale to halftone converter. Pixels arrive in raster order
// over a valid/ready handshake. Each pixel is quantised to one bit, and each
// completed row is emitted as a single L-bit word over a second valid/ready
// handshake.
//
// Build option:
//   HALFTONE_DIFFUSION_EN  defined   : Floyd-Steinberg error diffusion. The
//                                      right-hand error is a carry register;
//                                      the next-row errors live in one row
//                                      buffer.
//   HALFTONE_DIFFUSION_EN  undefined : plain threshold at 2^(W-1). The carry
//                                      and error storage are not built.
//
// Ports:
//   clock          : single clock; all state changes on the rising edge
//   reset          : asynchronous, active-low; clears all state
//   pixel_in       : unsigned W-bit pixel
//   pixel_valid    : pixel_in / pixel_sof valid
//   pixel_sof      : pixel is row 0, column 0 of a new frame (resync)
//   pixel_ready    : pixel accepted when pixel_valid && pixel_ready
//   htpv_row       : halftone row; bit 1 is column 1
//   htpv_valid     : htpv_row valid
//   htpv_ready     : row taken when htpv_valid && htpv_ready
//   htpv_row_index : 0-based row number of htpv_row
//   htpv_frame_end : htpv_row is the last row of the frame
module halftone_stream_converter #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROW_LENGTH  = 8,
  parameter int NUM_ROWS    = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  input  logic                   pixel_sof,
  output logic                   pixel_ready,
  output logic [1:ROW_LENGTH]    htpv_row,
  output logic                   htpv_valid,
  input  logic                   htpv_ready,
  output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] htpv_row_index,
  output logic                   htpv_frame_end
);
  localparam int W  = PIXEL_WIDTH;
  localparam int L  = ROW_LENGTH;
  localparam int R  = NUM_ROWS;
  localparam int CW = $clog2(L);
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

  // HOLD is encoded with bit 1 set so that htpv_valid is a plain flop output.
  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, HOLD = 2'b10} state_t;

  state_t        state_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [1:L]    row_buf_reg;
  logic [1:L]    row_buf_next;
  logic [1:L]    htpv_row_reg;
  logic [RW-1:0] htpv_row_index_reg;
  logic          htpv_frame_end_reg;

  logic          accept;
  logic          last_col;
  logic          row_wrap;
  logic          bit_b;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;

  // A start-of-frame pixel is processed as if the counters were already at 0.
  assign accept   = pixel_valid && pixel_ready;
  assign col_eff  = pixel_sof ? '0 : col_reg;
  assign row_eff  = pixel_sof ? '0 : row_reg;
  assign last_col = (col_eff == COL_LAST);
  assign row_wrap = (row_eff == ROW_LAST);

  // Only the last column has to wait for the output register to drain.
  assign pixel_ready = !((col_reg == COL_LAST) && state_reg[1] && !htpv_ready);

`ifdef HALFTONE_DIFFUSION_EN
  localparam int EW = W + 3;
  localparam int PW = EW + 3;
  localparam logic signed [EW-1:0] V_HALF = EW'(1 << (W - 1));
  localparam logic signed [EW-1:0] V_FULL = EW'((1 << W) - 1);

  logic signed [EW-1:0] carry_reg;
  logic signed [EW-1:0] carry_eff;
  logic signed [EW-1:0] cur_sel;
  logic signed [EW-1:0] v;
  logic signed [EW-1:0] e_raw;
  logic signed [EW-1:0] e;
  logic signed [PW-1:0] e_ext;
  logic signed [EW-1:0] d7, d5, d3, d1;
  logic signed [EW-1:0] err_cur_w [L];

  assign carry_eff = pixel_sof ? '0 : carry_reg;
  assign cur_sel   = pixel_sof ? '0 : err_cur_w[col_eff];
  assign v         = $signed({3'b000, pixel_in}) + carry_eff + cur_sel;
  assign bit_b     = (v >= V_HALF);
  assign e_raw     = bit_b ? (v - V_FULL) : v;

  always_comb begin
    e = e_raw;
    if (e_raw > V_FULL) begin
      e = V_FULL;
    end else if (e_raw < -V_FULL) begin
      e = -V_FULL;
    end
  end

  // Weights built from shifts and adds; >>> on the signed value rounds
  // toward minus infinity.
  assign e_ext = {{(PW - EW){e[EW-1]}}, e};
  assign d7 = EW'(((e_ext <<< 3) - e_ext) >>> 4);
  assign d5 = EW'(((e_ext <<< 2) + e_ext) >>> 4);
  assign d3 = EW'(((e_ext <<< 1) + e_ext) >>> 4);
  assign d1 = EW'(e_ext >>> 4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_reg <= '0;
    end else if (accept) begin
      carry_reg <= last_col ? '0 : d7;
    end
  end

  // Per-column error storage. err_nxt for column gi receives 5/16 from its
  // own pixel, 1/16 from the pixel to its left and 3/16 from the pixel to
  // its right.
  for (genvar gi = 0; gi < L; gi++) begin : g_err
    logic signed [EW-1:0] cur_reg;
    logic signed [EW-1:0] nxt_reg;
    logic signed [EW-1:0] nxt_upd;
    logic signed [EW-1:0] from_self;
    logic signed [EW-1:0] from_left;
    logic signed [EW-1:0] from_right;

    assign from_self = (col_eff == CW'(gi)) ? d5 : '0;
    if (gi > 0) begin : g_left
      assign from_left = (col_eff == CW'(gi - 1)) ? d1 : '0;
    end else begin : g_no_left
      assign from_left = '0;
    end
    if (gi < L - 1) begin : g_right
      assign from_right = (col_eff == CW'(gi + 1)) ? d3 : '0;
    end else begin : g_no_right
      assign from_right = '0;
    end
    assign nxt_upd = (pixel_sof ? '0 : nxt_reg) + from_self + from_left + from_right;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cur_reg <= '0;
        nxt_reg <= '0;
      end else if (accept) begin
        if (last_col) begin
          cur_reg <= row_wrap ? '0 : nxt_upd;
          nxt_reg <= '0;
        end else begin
          if (pixel_sof) begin
            cur_reg <= '0;
          end
          nxt_reg <= nxt_upd;
        end
      end
    end

    assign err_cur_w[gi] = cur_reg;
  end
`else
  localparam logic [W-1:0] PIX_HALF = W'(1 << (W - 1));

  assign bit_b = (pixel_in >= PIX_HALF);
`endif

  // Current pixel's bit merged into the row under construction.
  for (genvar gi = 0; gi < L; gi++) begin : g_bit
    assign row_buf_next[gi+1] = (col_eff == CW'(gi)) ? bit_b : row_buf_reg[gi+1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      col_reg            <= '0;
      row_reg            <= '0;
      row_buf_reg        <= '0;
      htpv_row_reg       <= '0;
      htpv_row_index_reg <= '0;
      htpv_frame_end_reg <= 1'b0;
    end else begin
      if (accept) begin
        row_buf_reg <= row_buf_next;
        if (last_col) begin
          col_reg <= '0;
          row_reg <= row_wrap ? '0 : row_eff + RW'(1);
        end else begin
          col_reg <= col_eff + CW'(1);
          row_reg <= row_eff;
        end
      end

      // Loading a new row takes priority: a handshake on the same edge just
      // retires the old row while valid stays high.
      if (accept && last_col) begin
        htpv_row_reg       <= row_buf_next;
        htpv_row_index_reg <= row_eff;
        htpv_frame_end_reg <= row_wrap;
        state_reg          <= HOLD;
      end else if (state_reg == HOLD && htpv_ready) begin
        state_reg <= FILL;
      end else if (state_reg == IDLE && accept) begin
        state_reg <= FILL;
      end
    end
  end

  assign htpv_valid     = state_reg[1];
  assign htpv_row       = htpv_row_reg;
  assign htpv_row_index = htpv_row_index_reg;
  assign htpv_frame_end = htpv_frame_end_reg;

endmodule

// File: tb/tb_halftone_stream_converter.sv
module tb_halftone_stream_converter;
  localparam int W = 8;
  localparam int L = 8;
  localparam int R = 6;
`ifdef HALFTONE_DIFFUSION_EN
  localparam logic [7:0] ROW128 = 8'hAA;
`else
  localparam logic [7:0] ROW128 = 8'hFF;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pixel_in = '0;
  logic         pixel_valid = 1'b0;
  logic         pixel_sof = 1'b0;
  logic         pixel_ready;
  logic [1:L]   htpv_row;
  logic         htpv_valid;
  logic         htpv_ready = 1'b1;
  logic [2:0]   htpv_row_index;
  logic         htpv_frame_end;

  halftone_stream_converter #(
    .PIXEL_WIDTH(W), .ROW_LENGTH(L), .NUM_ROWS(R)
  ) dut (
    .clock(clock), .reset(reset),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_sof(pixel_sof),
    .pixel_ready(pixel_ready),
    .htpv_row(htpv_row), .htpv_valid(htpv_valid), .htpv_ready(htpv_ready),
    .htpv_row_index(htpv_row_index), .htpv_frame_end(htpv_frame_end)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] row;
    int         idx;
    bit         fe;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // ---------------- reference model ----------------
  int         m_col = 0;
  int         m_row = 0;
  logic [7:0] m_bits = '0;
`ifdef HALFTONE_DIFFUSION_EN
  int m_carry = 0;
  int m_cur[L];
  int m_nxt[L];
`endif

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
`ifdef HALFTONE_DIFFUSION_EN
    m_carry = 0;
    for (int i = 0; i < L; i++) begin
      m_cur[i] = 0;
      m_nxt[i] = 0;
    end
`endif
  endtask

  task automatic model_accept(input int p, input bit sof, output bit last,
                              output logic [7:0] rowv, output int ridx);
    bit b;
`ifdef HALFTONE_DIFFUSION_EN
    int v;
    int e;
`endif
    if (sof) model_reset();
`ifdef HALFTONE_DIFFUSION_EN
    v = p + m_carry + m_cur[m_col];
    b = (v >= 128);
    e = v - (b ? 255 : 0);
    if (e > 255) e = 255;
    else if (e < -255) e = -255;
    if (m_col > 0) m_nxt[m_col-1] += (3 * e) >>> 4;
    m_nxt[m_col] += (5 * e) >>> 4;
    if (m_col < L - 1) m_nxt[m_col+1] += e >>> 4;
    m_carry = (7 * e) >>> 4;
`else
    b = (p >= 128);
`endif
    m_bits[7 - m_col] = b;
    last = (m_col == L - 1);
    rowv = m_bits;
    ridx = m_row;
    if (last) begin
`ifdef HALFTONE_DIFFUSION_EN
      for (int i = 0; i < L; i++) begin
        m_cur[i] = m_nxt[i];
        m_nxt[i] = 0;
      end
      m_carry = 0;
`endif
      if (m_row == R - 1) begin
        m_row = 0;
`ifdef HALFTONE_DIFFUSION_EN
        for (int i = 0; i < L; i++) m_cur[i] = 0;
`endif
      end else begin
        m_row++;
      end
      m_col = 0;
    end else begin
      m_col++;
    end
  endtask

  // Model the accepted pixel and push the expected row when it completes.
  task automatic model_and_push(input logic [7:0] p, input bit sof,
                                input bit known, input logic [7:0] kval);
    bit         last;
    logic [7:0] rowv;
    int         ridx;
    model_accept(int'(p), sof, last, rowv, ridx);
    if (last) sb_q.push_back('{row: (known ? kval : rowv), idx: ridx, fe: (ridx == R - 1)});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_pixel(input logic [7:0] p, input bit sof,
                             input bit known, input logic [7:0] kval);
    int n = 0;
    pixel_in = p;
    pixel_sof = sof;
    pixel_valid = 1'b1;
    @(negedge clock);
    while (!pixel_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!pixel_ready) begin
      check("accept_timeout", 32'(pixel_ready), 32'd1);
      pixel_valid = 1'b0;
      pixel_sof = 1'b0;
      return;
    end
    model_and_push(p, sof, known, kval);
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
    pixel_sof = 1'b0;
  endtask

  task automatic drive_const_row(input logic [7:0] p, input bit sof,
                                 input bit known, input logic [7:0] kval);
    for (int c = 0; c < L; c++) drive_pixel(p, sof && (c == 0), known, kval);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // ---------------- output monitor ----------------
  bit         hold_prev = 1'b0;
  logic [1:L] prev_row;
  logic [2:0] prev_idx;
  logic       prev_fe;

  always @(negedge clock) begin
    if (reset && hold_prev) begin
      check("hold_valid", 32'(htpv_valid), 32'd1);
      check("hold_row", 32'(htpv_row), 32'(prev_row));
      check("hold_index", 32'(htpv_row_index), 32'(prev_idx));
      check("hold_frame_end", 32'(htpv_frame_end), 32'(prev_fe));
    end
    if (reset && htpv_valid && htpv_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_row", 32'(htpv_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("row idx=%0d value=%h expected=%h frame_end=%0d",
                 htpv_row_index, htpv_row, mon_e.row, htpv_frame_end);
        check("row_value", 32'(htpv_row), 32'(mon_e.row));
        check("row_index", 32'(htpv_row_index), 32'(mon_e.idx));
        check("frame_end", 32'(htpv_frame_end), 32'(mon_e.fe));
      end
    end
    hold_prev = reset && htpv_valid && !htpv_ready;
    prev_row  = htpv_row;
    prev_idx  = htpv_row_index;
    prev_fe   = htpv_frame_end;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] pix;       // column 1 in the top byte
    bit          sof;
    bit          on_known;  // exp_on is a hand-derived value
    logic [7:0]  exp_on;
    logic [7:0]  exp_off;
  } vec_t;
  vec_t vecs[24];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_ready"}, 32'(pixel_ready), 32'd1);
    check({tag, "_htpv_valid"}, 32'(htpv_valid), 32'd0);
    check({tag, "_htpv_row"}, 32'(htpv_row), 32'd0);
    check({tag, "_htpv_row_index"}, 32'(htpv_row_index), 32'd0);
    check({tag, "_htpv_frame_end"}, 32'(htpv_frame_end), 32'd0);
  endtask

  initial begin
    // Stripe frame, constant 128, constant 64, horizontal gradient.
    for (int r = 0; r < R; r++) begin
      vecs[r]      = '{pix: (r < 3) ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF,
                       sof: (r == 0), on_known: 1'b1,
                       exp_on: (r < 3) ? 8'hF0 : 8'h0F, exp_off: (r < 3) ? 8'hF0 : 8'h0F};
      vecs[R+r]    = '{pix: 64'h8080_8080_8080_8080, sof: (r == 0), on_known: (r == 0),
                       exp_on: 8'hAA, exp_off: 8'hFF};
      vecs[2*R+r]  = '{pix: 64'h4040_4040_4040_4040, sof: (r == 0), on_known: (r == 0),
                       exp_on: 8'h00, exp_off: 8'h00};
      vecs[3*R+r]  = '{pix: 64'h0020_4060_80A0_C0E0, sof: (r == 0), on_known: 1'b0,
                       exp_on: 8'h00, exp_off: 8'h0F};
    end

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Table-driven frames at full throughput.
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < L; c++) begin
`ifdef HALFTONE_DIFFUSION_EN
        drive_pixel(vecs[i].pix[63 - 8*c -: 8], vecs[i].sof && (c == 0),
                    vecs[i].on_known, vecs[i].exp_on);
`else
        drive_pixel(vecs[i].pix[63 - 8*c -: 8], vecs[i].sof && (c == 0),
                    1'b1, vecs[i].exp_off);
`endif
      end
    end
    drain();

    // Backpressure over two rows, then a same-edge handover.
    htpv_ready = 1'b0;
    drive_const_row(8'd128, 1'b1, 1'b1, ROW128);
    for (int c = 0; c < L - 1; c++) drive_pixel(8'd128, 1'b0, 1'b0, 8'h00);
    pixel_in = 8'd128;
    pixel_sof = 1'b0;
    pixel_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_pixel_ready_low", 32'(pixel_ready), 32'd0);
      check("bp_first_row_held", 32'(htpv_row), 32'(ROW128));
      @(posedge clock);
      #1;
    end
    htpv_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", 32'(pixel_ready), 32'd1);
    model_and_push(8'd128, 1'b0, 1'b0, 8'h00);
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
    @(negedge clock);
    check("bp_handover_valid", 32'(htpv_valid), 32'd1);
    @(posedge clock);
    #1;
    drain();

    // Resync at row 3, column 5: the next row is a fresh row 0.
    for (int c = 0; c < 4; c++) drive_pixel(8'd128, 1'b0, 1'b0, 8'h00);
    drive_const_row(8'd128, 1'b1, 1'b1, ROW128);
    drive_const_row(8'd128, 1'b0, 1'b0, 8'h00);
    drain();

    // Reset pulse in the middle of row 2.
    drive_const_row(8'd128, 1'b1, 1'b1, ROW128);
    for (int c = 0; c < 4; c++) drive_pixel(8'd128, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrow_reset");
    sb_q.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int c = 0; c < L - 1; c++) drive_pixel(8'd128, 1'b0, 1'b1, ROW128);
    check("latency_before_last", 32'(htpv_valid), 32'd0);
    drive_pixel(8'd128, 1'b0, 1'b1, ROW128);
    @(negedge clock);
    check("latency_valid_next_cycle", 32'(htpv_valid), 32'd1);
    @(posedge clock);
    #1;
    drain();

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
